// File: rtl/cv_leaf_collector_pkg.sv
// cv_leaf_collector_pkg: widths, FSM encoding and the cv slot helper
// shared by the leaf collector and its bench.
package cv_leaf_collector_pkg;

  localparam int HASH_W     = 256;
  localparam int NUM_LEAVES = 8;
  localparam int IDX_W      = 3;
  localparam int CV_W       = HASH_W * NUM_LEAVES;
  localparam int SLOT_W     = $clog2(CV_W);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    LAUNCH  = 3'd2,
    RELEASE = 3'd3,
    PRESENT = 3'd4
  } state_e;

  // Top bit of leaf i inside cv; leaf 0 sits in the MSBs.
  function automatic logic [SLOT_W-1:0] slot_msb(
    input logic [IDX_W-1:0] i
  );
    return SLOT_W'(CV_W - 1 - HASH_W * int'(i));
  endfunction

endpackage

// File: rtl/cv_leaf_collector.sv
// cv_leaf_collector: gathers 8 out-of-order commitments into cv,
// runs the tree start/end handshake and presents the captured root.
// Ports: round_start/salt_in open a round; leaf_valid/ready/idx/data
// feed commitments; cv/salt go to the tree with tree_start, which
// answers with tree_set_end/cvroot; root_valid/ready/data hand the
// root downstream; busy, dup_err report status.
module cv_leaf_collector
  import cv_leaf_collector_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              round_start,
  input  logic [HASH_W-1:0] salt_in,
  input  logic              leaf_valid,
  output logic              leaf_ready,
  input  logic [IDX_W-1:0]  leaf_idx,
  input  logic [HASH_W-1:0] leaf_data,
  output logic [CV_W-1:0]   cv,
  output logic [HASH_W-1:0] salt,
  output logic              tree_start,
  input  logic              tree_set_end,
  input  logic [HASH_W-1:0] cvroot,
  output logic              root_valid,
  input  logic              root_ready,
  output logic [HASH_W-1:0] root_data,
  output logic              busy,
  output logic              dup_err
);

  state_e state_q, state_d;

  logic [NUM_LEAVES-1:0] mask_q, mask_d;
  logic [NUM_LEAVES-1:0] hit;
  logic [CV_W-1:0]       cv_q, cv_d;
  logic [HASH_W-1:0]     salt_q, salt_d;
  logic [HASH_W-1:0]     root_q, root_d;
  logic                  dup_q, dup_d;
  logic                  take;

  assign hit  = NUM_LEAVES'(1) << leaf_idx;
  assign take = leaf_valid & leaf_ready;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cv_d    = cv_q;
    salt_d  = salt_q;
    root_d  = root_q;
    dup_d   = dup_q;
    unique case (state_q)
      IDLE: begin
        if (round_start) begin
          salt_d  = salt_in;
          mask_d  = '0;
          dup_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (take) begin
          // A repeated index is consumed but never overwrites.
          if ((mask_q & hit) != '0) begin
            dup_d = 1'b1;
          end else begin
            cv_d[slot_msb(leaf_idx) -: HASH_W] = leaf_data;
            mask_d = mask_q | hit;
          end
          // Leaving COLLECT here drops leaf_ready at once.
          if (&mask_d) state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (tree_set_end) begin
          root_d  = cvroot;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Hold off until the tree has seen start low.
        if (!tree_set_end) state_d = PRESENT;
      end
      PRESENT: begin
        if (root_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cv_q    <= '0;
      salt_q  <= '0;
      root_q  <= '0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cv_q    <= cv_d;
      salt_q  <= salt_d;
      root_q  <= root_d;
      dup_q   <= dup_d;
    end
  end

  assign leaf_ready = (state_q == COLLECT);
  assign tree_start = (state_q == LAUNCH);
  assign root_valid = (state_q == PRESENT);
  assign busy       = (state_q != IDLE);
  assign cv         = cv_q;
  assign salt       = salt_q;
  assign root_data  = root_q;
  assign dup_err    = dup_q;

endmodule

// File: tb/tb_cv_leaf_collector.sv
// tb_cv_leaf_collector: directed tables, corner sequences and random
// rounds checked against a round model and a behavioural tree.
module tb_cv_leaf_collector;
  import cv_leaf_collector_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              round_start = 1'b0;
  logic [HASH_W-1:0] salt_in = '0;
  logic              leaf_valid = 1'b0;
  logic              leaf_ready;
  logic [IDX_W-1:0]  leaf_idx = '0;
  logic [HASH_W-1:0] leaf_data = '0;
  logic [CV_W-1:0]   cv;
  logic [HASH_W-1:0] salt;
  logic              tree_start;
  logic              tree_set_end = 1'b0;
  logic [HASH_W-1:0] cvroot = '0;
  logic              root_valid;
  logic              root_ready = 1'b0;
  logic [HASH_W-1:0] root_data;
  logic              busy;
  logic              dup_err;

  int checks = 0;
  int errors = 0;

  int          tree_lat = 3;
  bit          use_fixed = 1'b0;
  logic [255:0] tree_fixed = '0;
  int          tcnt = 0;
  bit          ts_prev = 1'b0;
  logic [255:0] lv [8];

  typedef struct {
    logic [2:0]   idx;
    logic [255:0] data;
    bit           dup;
    bit           ts;
  } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;

  cv_leaf_collector dut (
    .clk(clk), .reset(reset),
    .round_start(round_start), .salt_in(salt_in),
    .leaf_valid(leaf_valid), .leaf_ready(leaf_ready),
    .leaf_idx(leaf_idx), .leaf_data(leaf_data),
    .cv(cv), .salt(salt),
    .tree_start(tree_start), .tree_set_end(tree_set_end),
    .cvroot(cvroot),
    .root_valid(root_valid), .root_ready(root_ready),
    .root_data(root_data),
    .busy(busy), .dup_err(dup_err)
  );

  function automatic logic [255:0] rotl(
    input logic [255:0] x, input int n);
    if (n == 0) return x;
    return (x << n) | (x >> (256 - n));
  endfunction

  // Expected root from the bench's own leaf list.
  function automatic logic [255:0] ref_root(
    input logic [255:0] a [8], input logic [255:0] s);
    logic [255:0] r;
    r = s;
    for (int i = 0; i < 8; i++) r ^= rotl(a[i], 8 * i);
    return r;
  endfunction

  // What the tree computes from the cv bus it is handed.
  function automatic logic [255:0] tree_root(
    input logic [CV_W-1:0] c, input logic [255:0] s);
    logic [255:0] r;
    r = s;
    for (int i = 0; i < 8; i++)
      r ^= rotl(c[CV_W-1-HASH_W*i -: HASH_W], 8 * i);
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Tree: raises end tree_lat cycles after start, clears it
  // one cycle after it sees start low.
  always @(posedge clk) begin
    if (reset) begin
      tree_set_end <= 1'b0;
      tcnt <= 0;
    end else if (tree_set_end) begin
      if (!tree_start) tree_set_end <= 1'b0;
    end else if (tree_start) begin
      if (tcnt + 1 >= tree_lat) begin
        tree_set_end <= 1'b1;
        cvroot <= use_fixed ? tree_fixed : tree_root(cv, salt);
        tcnt <= 0;
      end else begin
        tcnt <= tcnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (tree_start && !ts_prev) begin
      checks++;
      if (tree_set_end) begin
        errors++;
        $display("FAIL stale_end: tree_set_end=1 at start rise, exp 0");
      end
    end
    ts_prev = tree_start;
  endtask

  task automatic chk(input string nm,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout exp event", nm);
  endtask

  task automatic start_round(input logic [255:0] s);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    if (busy) fail_to("start_wait");
    salt_in = s;
    round_start = 1'b1;
    tick();
    round_start = 1'b0;
  endtask

  task automatic send_leaf(input logic [2:0] idx,
                           input logic [255:0] d);
    int n = 0;
    leaf_idx = idx;
    leaf_data = d;
    leaf_valid = 1'b1;
    while (!leaf_ready && n < 50) begin tick(); n++; end
    if (!leaf_ready) begin
      fail_to("leaf_ready");
      leaf_valid = 1'b0;
      return;
    end
    tick();
    leaf_valid = 1'b0;
  endtask

  task automatic wait_rv(input int budget);
    int n = 0;
    while (!root_valid && n < budget) begin tick(); n++; end
    if (!root_valid) fail_to("root_valid");
  endtask

  task automatic accept();
    root_ready = 1'b1;
    tick();
    root_ready = 1'b0;
  endtask

  task automatic run_rand_round(input bit dups);
    logic [255:0] s;
    int ord [8];
    bit exp_dup;
    int j;
    int t;
    s = rnd256();
    exp_dup = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lv[i] = rnd256();
      ord[i] = i;
    end
    for (int i = 7; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    tree_lat = int'($urandom_range(1, 6));
    start_round(s);
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (dups && k > 0 && $urandom_range(0, 3) == 0) begin
        j = int'($urandom_range(0, k - 1));
        send_leaf(3'(ord[j]), rnd256());
        exp_dup = 1'b1;
      end
      send_leaf(3'(ord[k]), lv[ord[k]]);
    end
    chk("rr_dup", dup_err, exp_dup);
    wait_rv(200);
    chk("rr_root", root_data, ref_root(lv, s));
    chk("rr_salt", salt, s);
    repeat ($urandom_range(0, 3)) tick();
    accept();
    chk("rr_idle", busy, 0);
  endtask

  initial begin
    logic [255:0] s;
    logic [255:0] held;
    int rise;
    int fall;
    int rv;

    tbl[0] = '{3'd3, 256'h3,  1'b0, 1'b0};
    tbl[1] = '{3'd3, 256'hFF, 1'b1, 1'b0};
    tbl[2] = '{3'd0, {8{32'h0}}, 1'b1, 1'b0};
    tbl[3] = '{3'd1, {8{32'h1}}, 1'b1, 1'b0};
    tbl[4] = '{3'd2, {8{32'h2}}, 1'b1, 1'b0};
    tbl[5] = '{3'd4, {8{32'h4}}, 1'b1, 1'b0};
    tbl[6] = '{3'd5, {8{32'h5}}, 1'b1, 1'b0};
    tbl[7] = '{3'd6, {8{32'h6}}, 1'b1, 1'b0};
    tbl[8] = '{3'd7, {8{32'h7}}, 1'b1, 1'b1};

    // Reset state
    tick();
    tick();
    chk("rst_ready", leaf_ready, 0);
    chk("rst_start", tree_start, 0);
    chk("rst_rv", root_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dup", dup_err, 0);
    chk("rst_salt", salt, 0);
    chk("rst_root", root_data, 0);
    chk("rst_cv", 256'(|cv), 0);
    reset = 1'b0;
    tick();
    chk("idle_ready", leaf_ready, 0);

    // In-order fill
    tree_lat = 5;
    s = {32{8'hA5}};
    start_round(s);
    chk("io_salt", salt, s);
    chk("io_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      lv[i] = {8{32'(i)}};
      send_leaf(3'(i), lv[i]);
      chk($sformatf("io_start%0d", i), tree_start, (i == 7));
      chk($sformatf("io_ready%0d", i), leaf_ready, (i != 7));
    end
    chk("io_cv_top", cv[2047:1792], lv[0]);
    chk("io_cv_bot", cv[255:0], lv[7]);
    chk("io_dup", dup_err, 0);
    wait_rv(100);
    chk("io_root", root_data, ref_root(lv, s));
    accept();
    chk("io_rv_drop", root_valid, 0);
    chk("io_idle", busy, 0);

    // Reverse order, slow tree, end-to-valid timing
    use_fixed = 1'b1;
    tree_fixed = 256'h1234;
    tree_lat = 40;
    start_round(rnd256());
    for (int i = 7; i >= 0; i--) send_leaf(3'(i), {8{32'(i)}});
    rise = -1;
    fall = -1;
    rv = -1;
    for (int c = 0; c < 200 && rv < 0; c++) begin
      tick();
      if (rise < 0 && tree_set_end) rise = c;
      if (rise >= 0 && fall < 0 && !tree_set_end) fall = c;
      if (rv < 0 && root_valid) rv = c;
    end
    chk("rev_root", root_data, 256'h1234);
    chk("rev_rv_after_fall", 256'(rv - fall), 1);
    chk("rev_min_lat", 256'(rv - rise >= 2), 1);
    chk("rev_cv_top", cv[2047:1792], {8{32'h0}});
    accept();
    use_fixed = 1'b0;

    // Duplicate index, table driven
    tree_lat = 5;
    s = rnd256();
    start_round(s);
    for (int i = 0; i < 9; i++) begin
      send_leaf(tbl[i].idx, tbl[i].data);
      chk($sformatf("dup_err%0d", i), dup_err, tbl[i].dup);
      chk($sformatf("dup_start%0d", i), tree_start, tbl[i].ts);
    end
    chk("dup_slot3", cv[2047-256*3 -: 256], 256'h3);
    for (int i = 0; i < 8; i++) lv[i] = {8{32'(i)}};
    lv[3] = 256'h3;
    wait_rv(100);
    chk("dup_root", root_data, ref_root(lv, s));
    accept();

    // Backpressure with an ignored round_start
    tree_lat = 3;
    s = rnd256();
    start_round(s);
    for (int i = 0; i < 8; i++) begin
      lv[i] = rnd256();
      send_leaf(3'(i), lv[i]);
    end
    wait_rv(100);
    held = ref_root(lv, s);
    chk("bp_root", root_data, held);
    for (int c = 0; c < 10; c++) begin
      round_start = (c == 4);
      salt_in = ~s;
      tick();
      chk($sformatf("bp_rv%0d", c), root_valid, 1);
      chk($sformatf("bp_rd%0d", c), root_data, held);
    end
    round_start = 1'b0;
    chk("bp_salt", salt, s);
    accept();
    chk("bp_idle", busy, 0);
    tick();
    chk("bp_still_idle", busy, 0);

    // Reset while launching
    tree_lat = 40;
    start_round(rnd256());
    for (int i = 0; i < 8; i++) send_leaf(3'(i), rnd256());
    chk("rl_start", tree_start, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rl_start0", tree_start, 0);
    chk("rl_busy0", busy, 0);
    chk("rl_cv0", 256'(|cv), 0);
    chk("rl_rv0", root_valid, 0);

    // Recovery round, then back-to-back rounds
    run_rand_round(1'b0);
    run_rand_round(1'b0);

    // Random rounds with duplicates and gaps
    for (int r = 0; r < 20; r++) run_rand_round(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
